// File: rtl/npc_stage_ctrl_pkg.sv
// Shared definitions for the NPC multi-cycle sequencer.
// This file holds the state encodings, the opcodes the sequencer cares about,
// and the EBREAK encoding.
package npc_stage_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_IWAIT  = 4'd2,
        ST_DECODE = 4'd3,
        ST_EXEC   = 4'd4,
        ST_MEM    = 4'd5,
        ST_MWAIT  = 4'd6,
        ST_WB     = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  OPC_STORE   = 7'b0100011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // The states in which the sequencer waits on a memory handshake.
    // These states are guarded by the wait timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_IWAIT) || (s == ST_MEM) || (s == ST_MWAIT);
    endfunction

endpackage

// File: rtl/npc_stage_ctrl_wait_timer.sv
// npc_wait_timer: 8-bit wait counter with clear and enable.
// 'expired' is high in the cycle where the counter would step up to LIMIT.
// As a result, the owner leaves after exactly LIMIT enabled cycles.
module npc_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count_reg;

    // Counter update. Clear has priority over enable, so entering a wait state restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (en) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = en && !clear && (count_reg == LAST);

endmodule

// File: rtl/npc_stage_ctrl.sv
// npc_stage_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core.
// This block owns the PC and the instruction register, and it gates register-file writes.
// Every output is either a register or a decode of the state register.
module npc_stage_ctrl
    import npc_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] inst_q,
    input  logic [6:0]  opcode,
    input  logic        dec_wen,
    input  logic [31:0] next_pc,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic [31:0] pc_q,
    output logic        rf_wen,
    output logic        halt,
    output logic        halt_err,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
);

    state_t      state_reg, state_next;
    logic        err_next;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic        rf_wen_reg;
    logic        halt_reg;
    logic        halt_err_reg;
    logic [31:0] cycle_cnt_reg;
    logic [31:0] retire_cnt_reg;
    logic        tmr_clear, tmr_en, tmr_expired;
    logic        pc_misaligned;

    assign pc_misaligned = (next_pc[1:0] != 2'b00);

    // Next-state selection. err_next marks the halt transitions that are caused by faults.
    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_req_ready) begin
                    state_next = ST_IWAIT;
                end else if (tmr_expired) begin
                    state_next = ST_HALT;
                    err_next   = 1'b1;
                end
            end
            ST_IWAIT: begin
                if (imem_rsp_valid) begin
                    state_next = imem_rsp_err ? ST_HALT : ST_DECODE;
                    err_next   = imem_rsp_err;
                end else if (tmr_expired) begin
                    state_next = ST_HALT;
                    err_next   = 1'b1;
                end
            end
            ST_DECODE: state_next = (inst_reg == INST_EBREAK) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_req_ready) begin
                    state_next = ST_MWAIT;
                end else if (tmr_expired) begin
                    state_next = ST_HALT;
                    err_next   = 1'b1;
                end
            end
            ST_MWAIT: begin
                if (dmem_rsp_valid) begin
                    state_next = ST_WB;
                end else if (tmr_expired) begin
                    state_next = ST_HALT;
                    err_next   = 1'b1;
                end
            end
            ST_WB: begin
                state_next = pc_misaligned ? ST_HALT : ST_FETCH;
                err_next   = pc_misaligned;
            end
            ST_HALT: state_next = ST_HALT;
            default: begin
                state_next = ST_HALT;
                err_next   = 1'b1;
            end
        endcase
    end

    // The timer restarts on every entry into a wait state and runs while the sequencer sits in one.
    assign tmr_clear = (state_next != state_reg) && is_wait_state(state_next);
    assign tmr_en    = is_wait_state(state_reg);

    npc_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register and all architectural/registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= 32'd0;
            rf_wen_reg     <= 1'b0;
            halt_reg       <= 1'b0;
            halt_err_reg   <= 1'b0;
            cycle_cnt_reg  <= 32'd0;
            retire_cnt_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg != ST_HALT) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            end
            if ((state_reg == ST_IWAIT) && imem_rsp_valid && !imem_rsp_err) begin
                inst_reg <= imem_rsp_data;
            end
            // The write strobe is registered on entry to WB, so it is high for the single WB cycle.
            // A misaligned target is already visible from execute, and it suppresses the write.
            rf_wen_reg <= (state_next == ST_WB) && dec_wen && !pc_misaligned;
            if ((state_reg == ST_WB) && (state_next == ST_FETCH)) begin
                pc_reg         <= next_pc;
                retire_cnt_reg <= retire_cnt_reg + 32'd1;
            end
            if ((state_next == ST_HALT) && (state_reg != ST_HALT)) begin
                halt_reg     <= 1'b1;
                halt_err_reg <= err_next;
            end
        end
    end

    assign imem_req_valid = (state_reg == ST_FETCH);
    assign dmem_req_valid = (state_reg == ST_MEM);
    assign imem_addr      = pc_reg;
    assign pc_q           = pc_reg;
    assign inst_q         = inst_reg;
    assign rf_wen         = rf_wen_reg;
    assign halt           = halt_reg;
    assign halt_err       = halt_err_reg;
    assign cycle_cnt      = cycle_cnt_reg;
    assign retire_cnt     = retire_cnt_reg;

endmodule

// File: tb/tb_npc_stage_ctrl.sv
// Directed testbench for npc_stage_ctrl. The bench drives the memory handshakes and the decoder inputs by hand.
module tb_npc_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] inst_q;
    logic [6:0]  opcode;
    logic        dec_wen;
    logic [31:0] next_pc;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_rsp_valid;
    logic [31:0] pc_q;
    logic        rf_wen;
    logic        halt;
    logic        halt_err;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    npc_stage_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_q         (inst_q),
        .opcode         (opcode),
        .dec_wen        (dec_wen),
        .next_pc        (next_pc),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_rsp_valid (dmem_rsp_valid),
        .pc_q           (pc_q),
        .rf_wen         (rf_wen),
        .halt           (halt),
        .halt_err       (halt_err),
        .cycle_cnt      (cycle_cnt),
        .retire_cnt     (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever loses its way.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        opcode         = 7'd0;
        dec_wen        = 1'b0;
        next_pc        = 32'd0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    // After this task returns, the DUT sits in IDLE (cycle 0). Rising edge number k moves it into cycle k.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one instruction response and its decode. Call this with the DUT just entered into IWAIT.
    task automatic respond(input logic [31:0] inst, input logic [6:0] opc,
                           input logic wen, input logic [31:0] npc);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst;
        opcode         = opc;
        dec_wen        = wen;
        next_pc        = npc;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        drive_idle();
        #12;
        // Reset state
        check("rst_pc", pc_q, 32'h8000_0000);
        check("rst_inst", inst_q, 32'd0);
        check("rst_ivalid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_dvalid", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_halt", {30'd0, halt, halt_err}, 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_ivalid", {31'd0, imem_req_valid}, 32'd0);

        // addi with zero-wait imem: FETCH in cycle 1, WB in cycle 5
        tick();                                   // cycle 1 FETCH
        check("addi_ivalid_c1", {31'd0, imem_req_valid}, 32'd1);
        check("addi_iaddr", imem_addr, 32'h8000_0000);
        tick();                                   // cycle 2 IWAIT
        check("addi_ivalid_c2", {31'd0, imem_req_valid}, 32'd0);
        respond(32'h0010_0093, 7'b0010011, 1'b1, 32'h8000_0004);
        tick();                                   // cycle 3 DECODE
        imem_rsp_valid = 1'b0;
        check("addi_inst_q", inst_q, 32'h0010_0093);
        tick();                                   // cycle 4 EXEC
        check("addi_rfwen_c4", {31'd0, rf_wen}, 32'd0);
        tick();                                   // cycle 5 WB
        check("addi_rfwen_c5", {31'd0, rf_wen}, 32'd1);
        check("addi_pc_wb", pc_q, 32'h8000_0000);
        tick();                                   // cycle 6 FETCH
        check("addi_rfwen_c6", {31'd0, rf_wen}, 32'd0);
        check("addi_pc", pc_q, 32'h8000_0004);
        check("addi_retire", retire_cnt, 32'd1);
        check("addi_cycle", cycle_cnt, 32'd6);
        check("addi_ivalid_c6", {31'd0, imem_req_valid}, 32'd1);

        // lw: dmem_req_ready arrives only in the 4th MEM cycle
        tick();                                   // cycle 7 IWAIT
        respond(32'h0000_A103, 7'b0000011, 1'b1, 32'h8000_0008);
        tick();                                   // cycle 8 DECODE
        imem_rsp_valid = 1'b0;
        tick();                                   // cycle 9 EXEC
        tick();                                   // cycle 10 MEM
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lw_dvalid_%0d", i), {31'd0, dmem_req_valid}, 32'd1);
            if (i == 3) dmem_req_ready = 1'b1;
            tick();
        end                                       // cycle 14 MWAIT
        dmem_req_ready = 1'b0;
        check("lw_dvalid_mwait", {31'd0, dmem_req_valid}, 32'd0);
        dmem_rsp_valid = 1'b1;
        tick();                                   // cycle 15 WB (10th cycle from fetch at 6)
        dmem_rsp_valid = 1'b0;
        check("lw_rfwen_wb", {31'd0, rf_wen}, 32'd1);
        check("lw_retire_wb", retire_cnt, 32'd1);
        tick();                                   // cycle 16 FETCH
        check("lw_retire", retire_cnt, 32'd2);
        check("lw_pc", pc_q, 32'h8000_0008);
        check("lw_cycle", cycle_cnt, 32'd16);

        // jalr to a misaligned target: halt with error, no PC or retire update, no write
        tick();                                   // cycle 17 IWAIT
        respond(32'h0000_80E7, 7'b1100111, 1'b1, 32'h8000_0102);
        tick();                                   // cycle 18 DECODE
        imem_rsp_valid = 1'b0;
        tick();                                   // cycle 19 EXEC
        tick();                                   // cycle 20 WB
        check("jalr_rfwen_wb", {31'd0, rf_wen}, 32'd0);
        check("jalr_halt_wb", {31'd0, halt}, 32'd0);
        tick();                                   // cycle 21 HALT
        check("jalr_halt", {30'd0, halt, halt_err}, 32'd3);
        check("jalr_pc", pc_q, 32'h8000_0008);
        check("jalr_retire", retire_cnt, 32'd2);
        check("jalr_rfwen", {31'd0, rf_wen}, 32'd0);
        check("jalr_cycle", cycle_cnt, 32'd21);
        tick();
        tick();
        check("jalr_cycle_frozen", cycle_cnt, 32'd21);
        check("jalr_ivalid", {31'd0, imem_req_valid}, 32'd0);

        // ebreak: clean halt one cycle after DECODE, with cycle_cnt frozen
        do_reset();
        tick();                                   // cycle 1 FETCH
        tick();                                   // cycle 2 IWAIT
        respond(32'h0010_0073, 7'b1110011, 1'b0, 32'h8000_0004);
        tick();                                   // cycle 3 DECODE
        imem_rsp_valid = 1'b0;
        check("ebreak_halt_dec", {31'd0, halt}, 32'd0);
        tick();                                   // cycle 4 HALT
        check("ebreak_halt", {30'd0, halt, halt_err}, 32'd2);
        check("ebreak_cycle", cycle_cnt, 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ebreak_ivalid_%0d", i), {31'd0, imem_req_valid}, 32'd0);
        end
        check("ebreak_cycle_frozen", cycle_cnt, 32'd4);
        check("ebreak_retire", retire_cnt, 32'd0);

        // Asynchronous reset while waiting in MWAIT for a store acknowledgement
        do_reset();
        tick();                                   // cycle 1 FETCH
        tick();                                   // cycle 2 IWAIT
        respond(32'h0010_0093, 7'b0010011, 1'b1, 32'h8000_0004);
        tick();                                   // cycle 3 DECODE
        imem_rsp_valid = 1'b0;
        tick();                                   // cycle 4 EXEC
        tick();                                   // cycle 5 WB
        tick();                                   // cycle 6 FETCH
        tick();                                   // cycle 7 IWAIT
        respond(32'h0020_A023, 7'b0100011, 1'b0, 32'h8000_0008);
        dmem_req_ready = 1'b1;
        tick();                                   // cycle 8 DECODE
        imem_rsp_valid = 1'b0;
        tick();                                   // cycle 9 EXEC
        tick();                                   // cycle 10 MEM
        check("sw_dvalid", {31'd0, dmem_req_valid}, 32'd1);
        tick();                                   // cycle 11 MWAIT
        dmem_req_ready = 1'b0;
        tick();                                   // cycle 12 MWAIT
        check("sw_pc_before", pc_q, 32'h8000_0004);
        check("sw_retire_before", retire_cnt, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc_q, 32'h8000_0000);
        check("arst_retire", retire_cnt, 32'd0);
        check("arst_cycle", cycle_cnt, 32'd0);
        check("arst_inst", inst_q, 32'd0);
        check("arst_valids", {30'd0, imem_req_valid, dmem_req_valid}, 32'd0);
        check("arst_flags", {29'd0, rf_wen, halt, halt_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();                                   // cycle 1 FETCH
        check("arst_refetch_valid", {31'd0, imem_req_valid}, 32'd1);
        check("arst_refetch_addr", imem_addr, 32'h8000_0000);

        // imem accepts but never responds: halt with error after exactly 255 IWAIT cycles
        tick();                                   // first IWAIT cycle
        n = 0;
        while (!halt && n < 400) begin
            n++;
            tick();
        end
        check("tmo_iwait_cycles", n, 32'd255);
        check("tmo_halt", {30'd0, halt, halt_err}, 32'd3);
        check("tmo_ivalid", {31'd0, imem_req_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
